// File: rtl/seven_segment_monitor.sv
// Passive monitor for a multiplexed seven-segment bus: rebuilds a coherent hex frame,
// checks per-digit dwell against a window and flags overlapping anodes.
module seven_segment_monitor #(
  parameter int unsigned NUM_DIGITS             = 8,
  parameter int unsigned CLK_FREQUENCY          = 100_000_000,
  parameter int unsigned MIN_SEGMENT_DISPLAY_US = 10_000,
  parameter int unsigned TOLERANCE_CLKS         = 2,
  parameter int unsigned ANODE_ACTIVE_LOW       = 1,
  parameter int unsigned SEGMENT_ACTIVE_LOW     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              segments,
  input  logic                    dp,
  input  logic [NUM_DIGITS-1:0]   anode,
  output logic                    new_value,
  output logic [4*NUM_DIGITS-1:0] display_val,
  output logic [NUM_DIGITS-1:0]   display_dp,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    timing_err,
  output logic                    multi_anode_err,
  output logic [15:0]             err_count
);

  localparam int unsigned DWELL_CLKS = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
  localparam int unsigned CW = $clog2(DWELL_CLKS + TOLERANCE_CLKS + 2) + 1;
  localparam int unsigned LO = (DWELL_CLKS > TOLERANCE_CLKS) ? DWELL_CLKS - TOLERANCE_CLKS : 0;
  localparam int unsigned HI = DWELL_CLKS + TOLERANCE_CLKS;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LO_C  = CW'(LO);
  localparam logic [CW-1:0] HI_C  = CW'(HI);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic {SYNC, TRACK} state_t;

  function automatic logic [4:0] popcount(input logic [NUM_DIGITS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  logic [NUM_DIGITS-1:0]   an, an_prev_q;
  logic [6:0]              seg, seg_n;
  logic                    dpi;
  logic [4:0]              an_cnt, prev_cnt;
  logic                    sel, multi, prev_single, prev_multi, multi_entry;
  logic [IW-1:0]           idx;
  logic [3:0]              nib;
  logic                    nib_ok;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    tfail, publish;
  logic                    merr_q, merr_d;
  logic [15:0]             err_q, err_d;
  logic                    new_value_q, timing_err_q;

  logic [4*NUM_DIGITS-1:0] sh_val_q, pub_val_q;
  logic [NUM_DIGITS-1:0]   sh_ok_q, sh_dp_q, pub_ok_q, pub_dp_q;

  assign an  = (ANODE_ACTIVE_LOW != 0)   ? ~anode    : anode;
  assign seg = (SEGMENT_ACTIVE_LOW != 0) ? ~segments : segments;
  assign dpi = (SEGMENT_ACTIVE_LOW != 0) ? ~dp       : dp;
  assign seg_n = ~seg;

  assign an_cnt      = popcount(an);
  assign prev_cnt    = popcount(an_prev_q);
  assign sel         = (an_cnt == 5'd1);
  assign multi       = (an_cnt > 5'd1);
  assign prev_single = (prev_cnt == 5'd1);
  assign prev_multi  = (prev_cnt > 5'd1);
  assign multi_entry = multi && !prev_multi;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an[i]) idx = IW'(i);
    end
  end

  // Glyph table is written in active-low form (bit6 = A ... bit0 = G).
  always_comb begin
    nib    = '0;
    nib_ok = 1'b1;
    case (seg_n)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default: begin
        nib    = '0;
        nib_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    merr_d  = merr_q;
    tfail   = 1'b0;
    publish = 1'b0;
    if (multi) begin
      state_d = SYNC;
      cnt_d   = '0;
      mask_d  = '0;
      merr_d  = 1'b1;
    end else begin
      case (state_q)
        SYNC: begin
          cnt_d  = '0;
          mask_d = '0;
          if (sel) begin
            state_d = TRACK;
            cnt_d   = ONE_C;
          end
        end
        TRACK: begin
          if (cnt_q != '1) cnt_d = cnt_q + ONE_C;
          // Only a digit that was shown alone is judged; leaving a blank gap is not.
          if (an != an_prev_q) begin
            cnt_d = ONE_C;
            if (prev_single) begin
              if (cnt_q < LO_C || cnt_q > HI_C) tfail = 1'b1;
              else mask_d = mask_q | an_prev_q;
            end
          end
          if (mask_d == '1) begin
            publish = 1'b1;
            mask_d  = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if ((tfail || multi_entry) && err_q != '1) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      mask_q       <= '0;
      an_prev_q    <= '0;
      merr_q       <= 1'b0;
      err_q        <= '0;
      new_value_q  <= 1'b0;
      timing_err_q <= 1'b0;
      sh_val_q     <= '0;
      sh_ok_q      <= '0;
      sh_dp_q      <= '0;
      pub_val_q    <= '0;
      pub_ok_q     <= '0;
      pub_dp_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      an_prev_q    <= an;
      merr_q       <= merr_d;
      err_q        <= err_d;
      new_value_q  <= publish;
      timing_err_q <= tfail;
      if (sel) begin
        sh_val_q[4*idx +: 4] <= nib;
        sh_ok_q[idx]         <= nib_ok;
        sh_dp_q[idx]         <= dpi;
      end
      if (publish) begin
        pub_val_q <= sh_val_q;
        pub_ok_q  <= sh_ok_q;
        pub_dp_q  <= sh_dp_q;
      end
    end
  end

  assign new_value       = new_value_q;
  assign timing_err      = timing_err_q;
  assign multi_anode_err = merr_q;
  assign err_count       = err_q;
  assign display_val     = pub_val_q;
  assign display_dp      = pub_dp_q;
  assign digit_valid     = pub_ok_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Randomised run-level bench for seven_segment_monitor: a per-run model predicts
// publish, dwell errors and multi-anode events from the bus activity.
module tb_seven_segment_monitor;

  localparam int ND = 4;
  localparam int KB = 0;  // blank run
  localparam int KS = 1;  // single digit run
  localparam int KM = 2;  // multi-anode run

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    segments;
  logic          dp;
  logic [ND-1:0] anode;
  logic          new_value;
  logic [4*ND-1:0] display_val;
  logic [ND-1:0] display_dp;
  logic [ND-1:0] digit_valid;
  logic          timing_err;
  logic          multi_anode_err;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  seven_segment_monitor #(
    .NUM_DIGITS(ND),
    .CLK_FREQUENCY(1_000_000),
    .MIN_SEGMENT_DISPLAY_US(10),
    .TOLERANCE_CLKS(2),
    .ANODE_ACTIVE_LOW(1),
    .SEGMENT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .segments(segments),
    .dp(dp),
    .anode(anode),
    .new_value(new_value),
    .display_val(display_val),
    .display_dp(display_dp),
    .digit_valid(digit_valid),
    .timing_err(timing_err),
    .multi_anode_err(multi_anode_err),
    .err_count(err_count)
  );

  // Active-low glyphs indexed by hex value.
  logic [6:0] GLYPH [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0;
  int errors = 0;

  int         prev_kind, prev_digit, prev_len;
  logic [3:0] m_mask;
  logic [3:0] sh_val [ND];
  logic       sh_ok [ND], sh_dp [ND];
  logic [3:0] pub_val [ND];
  logic       pub_ok [ND], pub_dp [ND];
  int         m_err;
  logic       m_merr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] n, output logic ok);
    n  = 4'h0;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (GLYPH[k] == p) begin
        n  = 4'(k);
        ok = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] exp_val();
    logic [15:0] v;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = pub_val[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_ok();
    logic [3:0] v;
    for (int k = 0; k < ND; k++) v[k] = pub_ok[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_dp();
    logic [3:0] v;
    for (int k = 0; k < ND; k++) v[k] = pub_dp[k];
    return v;
  endfunction

  task automatic model_reset();
    prev_kind = KB;
    prev_digit = 0;
    prev_len = 0;
    m_mask = '0;
    m_err = 0;
    m_merr = 1'b0;
    for (int k = 0; k < ND; k++) begin
      sh_val[k] = '0; sh_ok[k] = 1'b0; sh_dp[k] = 1'b0;
      pub_val[k] = '0; pub_ok[k] = 1'b0; pub_dp[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    anode = '1;
    segments = '1;
    dp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_new_value", 32'(new_value), 32'd0);
    check_eq("rst_display_val", 32'(display_val), 32'd0);
    check_eq("rst_display_dp", 32'(display_dp), 32'd0);
    check_eq("rst_digit_valid", 32'(digit_valid), 32'd0);
    check_eq("rst_timing_err", 32'(timing_err), 32'd0);
    check_eq("rst_multi_err", 32'(multi_anode_err), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
  endtask

  // One run = the bus held constant for len cycles; the model judges the run that just ended.
  task automatic run(input int kind, input int digit, input int len,
                     input logic [6:0] pat, input logic dp_pin, input logic [3:0] multi_an);
    logic exp_nv, exp_tv;
    logic [3:0] n;
    logic ok;
    exp_nv = 1'b0;
    exp_tv = 1'b0;
    if (kind == KM) begin
      if (prev_kind != KM) m_err++;
      m_merr = 1'b1;
      m_mask = '0;
    end else if (prev_kind == KS) begin
      if (prev_len < 8 || prev_len > 12) begin
        exp_tv = 1'b1;
        m_err++;
      end else begin
        m_mask[prev_digit] = 1'b1;
        if (m_mask == 4'hF) begin
          exp_nv = 1'b1;
          m_mask = '0;
          for (int k = 0; k < ND; k++) begin
            pub_val[k] = sh_val[k]; pub_ok[k] = sh_ok[k]; pub_dp[k] = sh_dp[k];
          end
        end
      end
    end
    if (kind == KS) begin
      decode(pat, n, ok);
      sh_val[digit] = n;
      sh_ok[digit] = ok;
      sh_dp[digit] = ~dp_pin;
    end
    segments = pat;
    dp = dp_pin;
    if (kind == KB) anode = 4'hF;
    else if (kind == KS) anode = ~(4'b0001 << digit);
    else anode = ~multi_an;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      check_eq("new_value", 32'(new_value), (i == 0) ? 32'(exp_nv) : 32'd0);
      check_eq("timing_err", 32'(timing_err), (i == 0) ? 32'(exp_tv) : 32'd0);
      check_eq("display_val", 32'(display_val), 32'(exp_val()));
      check_eq("display_dp", 32'(display_dp), 32'(exp_dp()));
      check_eq("digit_valid", 32'(digit_valid), 32'(exp_ok()));
      check_eq("err_count", 32'(err_count), 32'(m_err));
      check_eq("multi_anode_err", 32'(multi_anode_err), 32'(m_merr));
    end
    prev_kind = kind;
    prev_digit = digit;
    prev_len = len;
  endtask

  task automatic sweep(input int l0, input int l1, input int l2, input int l3, input int gap);
    int lens [4];
    lens = '{l0, l1, l2, l3};
    for (int d = 0; d < ND; d++) begin
      run(KS, d, lens[d], GLYPH[d + 1], 1'b1, 4'h0);
      if (gap > 0) run(KB, 0, gap, 7'h7F, 1'b1, 4'h0);
    end
  endtask

  initial begin
    int kind, digit, len, a, b;
    logic [6:0] pat;
    logic [3:0] man;

    do_reset();

    // Clean sweep showing 1,2,3,4, closed by a short blank.
    sweep(10, 10, 10, 10, 0);
    run(KB, 0, 3, 7'h7F, 1'b1, 4'h0);
    check_eq("clean_val", 32'(display_val), 32'h4321);
    check_eq("clean_valid", 32'(digit_valid), 32'hF);
    check_eq("clean_err", 32'(err_count), 32'd0);

    // Overlong digit 2, then clean sweeps.
    sweep(10, 10, 14, 10, 0);
    sweep(10, 10, 10, 10, 0);
    run(KB, 0, 3, 7'h7F, 1'b1, 4'h0);

    // Two anodes active mid-sweep for 3 cycles.
    run(KS, 0, 10, GLYPH[5], 1'b1, 4'h0);
    run(KM, 0, 3, GLYPH[6], 1'b1, 4'b0011);
    sweep(10, 10, 10, 10, 0);
    run(KB, 0, 3, 7'h7F, 1'b1, 4'h0);
    check_eq("multi_sticky", 32'(multi_anode_err), 32'd1);

    // Blank gaps between digits, then window boundaries.
    sweep(10, 10, 10, 10, 5);
    sweep(8, 12, 7, 13, 0);
    sweep(12, 8, 8, 12, 2);

    // Illegal glyph with dp asserted on digit 0.
    run(KS, 0, 10, 7'b1111111, 1'b0, 4'h0);
    run(KS, 1, 10, GLYPH[9], 1'b1, 4'h0);
    run(KS, 2, 10, GLYPH[10], 1'b0, 4'h0);
    run(KS, 3, 10, GLYPH[15], 1'b1, 4'h0);
    run(KB, 0, 4, 7'h7F, 1'b1, 4'h0);
    check_eq("illegal_nibble", 32'(display_val[3:0]), 32'd0);
    check_eq("illegal_valid", 32'(digit_valid[0]), 32'd0);
    check_eq("illegal_dp", 32'(display_dp[0]), 32'd1);

    // Reset after two digits discards the partial frame.
    run(KS, 0, 10, GLYPH[3], 1'b1, 4'h0);
    run(KS, 1, 10, GLYPH[4], 1'b1, 4'h0);
    do_reset();
    run(KS, 2, 10, GLYPH[7], 1'b1, 4'h0);
    run(KS, 3, 10, GLYPH[8], 1'b1, 4'h0);
    sweep(10, 10, 10, 10, 0);
    run(KB, 0, 3, 7'h7F, 1'b1, 4'h0);

    // Random bus traffic.
    for (int r = 0; r < 400; r++) begin
      a = int'($urandom_range(0, 99));
      kind = (a < 80) ? KS : (a < 95) ? KB : KM;
      if (kind == KB && prev_kind == KB) kind = KS;
      if (kind == KM && prev_kind == KM) kind = KS;
      digit = int'($urandom_range(0, ND - 1));
      if (kind == KS && prev_kind == KS && digit == prev_digit) digit = (digit + 1) % ND;
      len = ($urandom_range(0, 99) < 80) ? int'($urandom_range(8, 12)) : int'($urandom_range(1, 20));
      if ($urandom_range(0, 99) < 80) pat = GLYPH[$urandom_range(0, 15)];
      else pat = 7'($urandom);
      a = int'($urandom_range(0, ND - 1));
      b = (a + int'($urandom_range(1, ND - 1))) % ND;
      man = (4'b0001 << a) | (4'b0001 << b) | (4'($urandom) & 4'($urandom));
      run(kind, digit, len, pat, 1'($urandom), man);
    end
    run(KB, 0, 3, 7'h7F, 1'b1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_monitor.md
Name: seven_segment_monitor

Overview:
- Synthesizable, parametrised monitor that sits on the multiplexed seven-segment bus (segments, dp, anode) between the display driver and the board pins.
- Reconstructs a frame-coherent hex value and decimal points for NUM_DIGITS digits, and checks per-digit dwell time against a window.
- Reports timing and multi-anode errors in hardware, for on-chip self-check and for bench use.
- Generalises the earlier single-purpose checker: configurable digit count, configurable polarity, blanking tolerance, and error counters.

Parameters:
- NUM_DIGITS, 8: number of anodes/digits (1..16).
- CLK_FREQUENCY, 100_000_000: clk frequency in Hz.
- MIN_SEGMENT_DISPLAY_US, 10_000: expected dwell per digit in us. DWELL_CLKS = CLK_FREQUENCY/1_000_000*MIN_SEGMENT_DISPLAY_US (localparam).
- TOLERANCE_CLKS, 2: allowed +/- deviation from DWELL_CLKS.
- ANODE_ACTIVE_LOW, 1: 1 = anode asserted low.
- SEGMENT_ACTIVE_LOW, 1: 1 = segments and dp asserted low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- segments  in  7  segment pattern; bit6 = A … bit0 = G.
- dp  in  1  decimal point.
- anode  in  NUM_DIGITS  digit enables.
- new_value  out  1  one-cycle pulse when a complete frame is published.
- display_val  out  4*NUM_DIGITS  published hex nibbles; digit i at [4i+:4].
- display_dp  out  NUM_DIGITS  published dp, active-high.
- digit_valid  out  NUM_DIGITS  1 = digit's pattern decoded to a legal hex glyph.
- timing_err  out  1  one-cycle pulse on a dwell-window violation.
- multi_anode_err  out  1  sticky; set when more than one anode is asserted.
- err_count  out  16  saturating count of timing violations plus multi-anode events.

Behaviour:
- Polarity normalisation:
  - Inputs are inverted per parameter to active-high internal signals an, seg, dpi.
  - an is registered once as an_d.
  - sel = an has exactly one bit set. blank = an==0. multi = popcount(an)>1.
- Decode table, active-low form:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F.
  - Any other pattern gives nibble 0 and valid 0.
- Shadow capture: each cycle sel=1, the active digit's shadow nibble, valid and dp load from the current inputs. Shadows are never visible directly.
- FSM states: SYNC, TRACK.
  - SYNC: dwell counter held at 0, collect mask = 0. Move to TRACK on the first cycle sel=1, with counter = 1.
  - TRACK: counter increments every cycle, saturating at 2^CW-1, CW = $clog2(DWELL_CLKS+TOLERANCE_CLKS+2)+1.
  - TRACK, on an != an_d where an_d was a single digit:
    - If counter < DWELL_CLKS-TOLERANCE_CLKS or counter > DWELL_CLKS+TOLERANCE_CLKS: timing_err pulses on the next cycle and err_count increments.
    - Otherwise the digit in an_d is ORed into the collect mask.
    - Counter restarts at 1.
  - Blank (an==0): legal gap. Its duration is not checked. The transition out of blank restarts the counter without a check.
  - multi=1 in either state: set multi_anode_err, increment err_count (once per entry into multi, not per cycle), suppress capture, go to SYNC.
- Publish:
  - When the collect mask reaches all ones, new_value pulses on the next cycle. In that same cycle display_val, display_dp and digit_valid load from the shadows, and the collect mask clears.
  - Outputs change only on publish, so a frame is always coherent.
- Latency: an anode change that completes the frame gives new_value exactly 1 cycle later.
- Simultaneous events: a timing failure on the completing digit blocks publish; that digit must dwell correctly in a later sweep. err_count increments once per cycle even if two events coincide.
- Saturation: err_count holds at 16'hFFFF.
- Reset:
  - All outputs go to 0, including multi_anode_err, err_count and display_val. Shadows, collect mask and counter clear; FSM enters SYNC.
  - Reset mid-frame discards partial collection.
  - multi_anode_err clears only on rst.

Test Plan:
- Setup for all scenarios: NUM_DIGITS=4, CLK_FREQUENCY=1_000_000, MIN_SEGMENT_DISPLAY_US=10 (DWELL_CLKS=10), TOLERANCE_CLKS=2, active-low.
- Clean sweep: anodes 1110,1101,1011,0111, 10 clocks each, showing 1,2,3,4 → new_value pulses one cycle after the 4th digit ends; display_val=16'h4321, digit_valid=4'hF, err_count=0.
- Dwell violation: digit 2 held 14 clocks → timing_err one pulse, err_count=1, no new_value that sweep; the next clean sweep publishes.
- Multi-anode: anode=1100 for 3 cycles mid-sweep → multi_anode_err=1 (sticky), err_count +1 (not +3), FSM resyncs; a subsequent clean sweep publishes.
- Blanking: 5-clock anode=1111 gaps between digits → no timing_err; frame publishes normally.
- Illegal glyph plus dp: digit 0 = 1111111 with dp low → display_val[3:0]=0, digit_valid[0]=0, display_dp[0]=1.
- Reset mid-frame: assert rst after 2 digits → all outputs 0; new_value only after a full new 4-digit sweep.
